// File: rtl/lb_debounce_if.sv
// ---------------------------------------------------------------------------
// lb_debounce_if : raw button pin in, debounced level and edge strobes out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lb_debounce_if;
  logic btn_in;
  logic db_level;
  logic db_press;
  logic db_release;

  modport slave (
    input  btn_in,
    output db_level,
    output db_press,
    output db_release
  );

  modport master (
    output btn_in,
    input  db_level,
    input  db_press,
    input  db_release
  );
endinterface

`default_nettype wire

// File: rtl/lb_debounce.sv
// ---------------------------------------------------------------------------
// lb_debounce : synchronizes and debounces a push-button; registered level
//               plus one-clock press/release strobes.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lb_debounce #(
  parameter int unsigned STABLE_COUNT  = 1000000,
  parameter int unsigned CNT_WIDTH     = 20,
  parameter bit          ACTIVE_LOW_IN = 1'b1
) (
  input  logic         clk,
  input  logic         resetb,
  lb_debounce_if.slave db_if
);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 w_pressed;
  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 level_q;
  logic                 press_q;
  logic                 release_q;

  // Sync flops reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= ACTIVE_LOW_IN;
      sync2_q <= ACTIVE_LOW_IN;
    end else begin
      sync1_q <= db_if.btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign w_pressed = sync2_q ^ ACTIVE_LOW_IN;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= REL;
      cnt_q     <= c_cnt_zero;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        REL: begin
          if (w_pressed) begin
            state_q <= REL_CHK;
            cnt_q   <= c_cnt_one;
          end
        end
        REL_CHK: begin
          if (!w_pressed) begin
            state_q <= REL;
            cnt_q   <= c_cnt_zero;
          end else if (cnt_q == c_cnt_last) begin
            state_q <= PRS;
            cnt_q   <= c_cnt_zero;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        PRS: begin
          if (!w_pressed) begin
            state_q <= PRS_CHK;
            cnt_q   <= c_cnt_one;
          end
        end
        PRS_CHK: begin
          if (w_pressed) begin
            state_q <= PRS;
            cnt_q   <= c_cnt_zero;
          end else if (cnt_q == c_cnt_last) begin
            state_q   <= REL;
            cnt_q     <= c_cnt_zero;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        default: begin
          state_q <= REL;
          cnt_q   <= c_cnt_zero;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign db_if.db_level   = level_q;
  assign db_if.db_press   = press_q;
  assign db_if.db_release = release_q;

endmodule

`default_nettype wire

// File: tb/tb_lb_debounce.sv
// ---------------------------------------------------------------------------
// tb_lb_debounce : directed bench for lb_debounce, both input polarities.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lb_debounce;

  localparam int unsigned SC = 8;
  localparam int unsigned CW = 4;
  localparam int          LAT_LO = 9;
  localparam int          LAT_HI = 11;

  logic clk = 1'b0;
  logic resetb;

  always #5 clk = ~clk;

  lb_debounce_if if_lo ();
  lb_debounce_if if_hi ();

  lb_debounce #(
    .STABLE_COUNT (SC),
    .CNT_WIDTH    (CW),
    .ACTIVE_LOW_IN(1'b1)
  ) u_dut_lo (
    .clk   (clk),
    .resetb(resetb),
    .db_if (if_lo)
  );

  lb_debounce #(
    .STABLE_COUNT (SC),
    .CNT_WIDTH    (CW),
    .ACTIVE_LOW_IN(1'b0)
  ) u_dut_hi (
    .clk   (clk),
    .resetb(resetb),
    .db_if (if_hi)
  );

  int total = 0;
  int bad   = 0;

  // Observation state for the DUT currently selected by sel_hi.
  int cyc = 0;
  int rise_cyc, fall_cyc, n_press, n_rel, n_bad_strobe;
  bit sel_hi;
  bit prev_lvl;

  function automatic logic get_lvl();
    return sel_hi ? if_hi.db_level : if_lo.db_level;
  endfunction

  function automatic logic get_press();
    return sel_hi ? if_hi.db_press : if_lo.db_press;
  endfunction

  function automatic logic get_rel();
    return sel_hi ? if_hi.db_release : if_lo.db_release;
  endfunction

  task automatic clear_stats(input bit hi);
    sel_hi       = hi;
    rise_cyc     = 0;
    fall_cyc     = 0;
    n_press      = 0;
    n_rel        = 0;
    n_bad_strobe = 0;
    prev_lvl     = get_lvl();
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge.
  task automatic step(input int n);
    logic lvl, pr, rl;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      lvl = get_lvl();
      pr  = get_press();
      rl  = get_rel();
      if (lvl && !prev_lvl && rise_cyc == 0) rise_cyc = cyc;
      if (!lvl && prev_lvl && fall_cyc == 0) fall_cyc = cyc;
      if (pr) begin
        n_press++;
        if (!(lvl && !prev_lvl)) n_bad_strobe++;
      end
      if (rl) begin
        n_rel++;
        if (!(!lvl && prev_lvl)) n_bad_strobe++;
      end
      if (pr && rl) n_bad_strobe++;
      prev_lvl = lvl;
    end
  endtask

  task automatic drive_btn(input bit hi, input bit pressed);
    if (hi) if_hi.btn_in = pressed;
    else    if_lo.btn_in = ~pressed;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    clear_stats(1'b0);
    step(5);
    #2 resetb = 1'b0;
    #1;
    total++;
    if (if_lo.db_level !== 1'b0) begin
      bad++; $display("FAIL reset_level: got %b expected 0", if_lo.db_level);
    end
    total++;
    if (if_lo.db_press !== 1'b0) begin
      bad++; $display("FAIL reset_press: got %b expected 0", if_lo.db_press);
    end
    total++;
    if (if_lo.db_release !== 1'b0) begin
      bad++; $display("FAIL reset_release: got %b expected 0", if_lo.db_release);
    end
    total++;
    if (if_hi.db_level !== 1'b0) begin
      bad++; $display("FAIL reset_level_hi: got %b expected 0", if_hi.db_level);
    end
    @(posedge clk);
    #1 resetb = 1'b1;
    clear_stats(1'b0);
    step(20);
    total++;
    if (n_press != 0 || n_rel != 0) begin
      bad++; $display("FAIL reset_idle_strobes: got press=%0d rel=%0d expected 0/0", n_press, n_rel);
    end
    total++;
    if (if_lo.db_level !== 1'b0) begin
      bad++; $display("FAIL reset_idle_level: got %b expected 0", if_lo.db_level);
    end
  endtask

  task automatic test_clean_press(input bit hi);
    int t0;
    clear_stats(hi);
    step(2);
    t0 = cyc;
    drive_btn(hi, 1'b1);
    step(20);
    total++;
    if (rise_cyc - t0 < LAT_LO || rise_cyc - t0 > LAT_HI) begin
      bad++; $display("FAIL clean_press_latency(hi=%0b): got %0d expected 10+-1", hi, rise_cyc - t0);
    end
    total++;
    if (n_press != 1 || n_rel != 0) begin
      bad++; $display("FAIL clean_press_count(hi=%0b): got press=%0d rel=%0d expected 1/0", hi, n_press, n_rel);
    end
    total++;
    if (get_lvl() !== 1'b1) begin
      bad++; $display("FAIL clean_press_level(hi=%0b): got %b expected 1", hi, get_lvl());
    end
    t0 = cyc;
    drive_btn(hi, 1'b0);
    step(20);
    total++;
    if (fall_cyc - t0 < LAT_LO || fall_cyc - t0 > LAT_HI) begin
      bad++; $display("FAIL clean_release_latency(hi=%0b): got %0d expected 10+-1", hi, fall_cyc - t0);
    end
    total++;
    if (n_press != 1 || n_rel != 1) begin
      bad++; $display("FAIL clean_release_count(hi=%0b): got press=%0d rel=%0d expected 1/1", hi, n_press, n_rel);
    end
    total++;
    if (n_bad_strobe != 0) begin
      bad++; $display("FAIL clean_strobe_align(hi=%0b): got %0d misaligned expected 0", hi, n_bad_strobe);
    end
    total++;
    if (get_lvl() !== 1'b0) begin
      bad++; $display("FAIL clean_release_level(hi=%0b): got %b expected 0", hi, get_lvl());
    end
  endtask

  task automatic test_bounce_reject();
    clear_stats(1'b0);
    for (int s = 0; s < 10; s++) begin
      if_lo.btn_in = (s % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    if_lo.btn_in = 1'b1;
    step(20);
    total++;
    if (n_press != 0 || n_rel != 0) begin
      bad++; $display("FAIL bounce_reject_strobes: got press=%0d rel=%0d expected 0/0", n_press, n_rel);
    end
    total++;
    if (rise_cyc != 0 || if_lo.db_level !== 1'b0) begin
      bad++; $display("FAIL bounce_reject_level: got rise_at=%0d level=%b expected 0/0", rise_cyc, if_lo.db_level);
    end
  endtask

  task automatic test_bounce_settle();
    int t0;
    clear_stats(1'b0);
    for (int s = 0; s < 6; s++) begin
      if_lo.btn_in = (s % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    t0 = cyc;
    if_lo.btn_in = 1'b0;
    step(20);
    total++;
    if (rise_cyc - t0 < LAT_LO || rise_cyc - t0 > LAT_HI) begin
      bad++; $display("FAIL settle_press_latency: got %0d expected 10+-1", rise_cyc - t0);
    end
    total++;
    if (n_press != 1) begin
      bad++; $display("FAIL settle_press_count: got %0d expected 1", n_press);
    end
    t0 = cyc;
    if_lo.btn_in = 1'b1;
    step(20);
    total++;
    if (fall_cyc - t0 < LAT_LO || fall_cyc - t0 > LAT_HI) begin
      bad++; $display("FAIL settle_release_latency: got %0d expected 10+-1", fall_cyc - t0);
    end
    total++;
    if (n_rel != 1 || n_bad_strobe != 0) begin
      bad++; $display("FAIL settle_release_count: got rel=%0d misaligned=%0d expected 1/0", n_rel, n_bad_strobe);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_stats(1'b0);
    if_lo.btn_in = 1'b0;
    step(15);
    total++;
    if (if_lo.db_level !== 1'b1) begin
      bad++; $display("FAIL mid_reset_pre_level: got %b expected 1", if_lo.db_level);
    end
    #2 resetb = 1'b0;
    #1;
    total++;
    if (if_lo.db_level !== 1'b0 || if_lo.db_press !== 1'b0 || if_lo.db_release !== 1'b0) begin
      bad++; $display("FAIL mid_reset_async: got level=%b press=%b rel=%b expected 0/0/0",
                      if_lo.db_level, if_lo.db_press, if_lo.db_release);
    end
    step(2);
    resetb = 1'b1;
    t0 = cyc;
    clear_stats(1'b0);
    step(20);
    total++;
    if (rise_cyc - t0 < LAT_LO || rise_cyc - t0 > LAT_HI) begin
      bad++; $display("FAIL mid_reset_repress_latency: got %0d expected 10+-1", rise_cyc - t0);
    end
    total++;
    if (n_press != 1 || n_rel != 0 || n_bad_strobe != 0) begin
      bad++; $display("FAIL mid_reset_repress_count: got press=%0d rel=%0d misaligned=%0d expected 1/0/0",
                      n_press, n_rel, n_bad_strobe);
    end
    if_lo.btn_in = 1'b1;
    step(20);
    total++;
    if (if_lo.db_level !== 1'b0) begin
      bad++; $display("FAIL mid_reset_final_level: got %b expected 0", if_lo.db_level);
    end
  endtask

  task automatic test_polarity();
    test_clean_press(1'b1);
    total++;
    if (if_lo.db_level !== 1'b0) begin
      bad++; $display("FAIL polarity_isolation: got %b expected 0", if_lo.db_level);
    end
  endtask

  initial begin
    resetb       = 1'b0;
    if_lo.btn_in = 1'b1;
    if_hi.btn_in = 1'b0;
    test_reset();
    test_clean_press(1'b0);
    test_bounce_reject();
    test_bounce_settle();
    test_reset_mid();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
